// File: rtl/bcd_pkg.sv
// bcd_pkg: shared states, constants and digit check for the BCD-to-binary converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam int BCD_DIGITS = 4;
  localparam int SHIFTS = 16;
  localparam int ADJ_THRESH = 8;
  localparam int ADJ_SUB = 3;
  localparam int BCD_MAX = 9;
  function automatic logic any_bad_digit(input logic [4*BCD_DIGITS-1:0] b);
    any_bad_digit = 1'b0;
    for (int k = 0; k < BCD_DIGITS; k++)
      if (b[4*k +: 4] > 4'(BCD_MAX)) any_bad_digit = 1'b1;
  endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: subtract 3 from a BCD digit that reached 8 or more after a right shift
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'(ADJ_THRESH)) ? d - 4'(ADJ_SUB) : d;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: 4-digit BCD to binary via reverse double-dabble, one bit per clock
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter bit CHECK_DIGITS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ones,
  input  logic [3:0]       tens,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       thousands,
  output logic [BIN_W-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             err
);
  if (BIN_W != 4 * BCD_DIGITS) begin : g_bad_width
    $error("bcd_to_bin_seq: BIN_W must equal 4 x BCD_DIGITS (16)");
  end
  state_t state, state_n;
  logic [2*BIN_W-1:0] work, work_n, sh;
  logic [BIN_W-1:0] adj, bcd_in, y_n;
  logic [4:0] cnt, cnt_n;
  logic err_n;
  assign bcd_in = {thousands, hundreds, tens, ones};
  assign sh = work >> 1;
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (.d(sh[BIN_W+4*i +: 4]), .q(adj[4*i +: 4]));
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  // state, work register, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      work <= '0;
      cnt <= '0;
      y <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      work <= work_n;
      cnt <= cnt_n;
      y <= y_n;
      err <= err_n;
    end
  end
  // capture on start, shift-and-adjust while converting, publish after the last shift
  always_comb begin
    state_n = state;
    work_n = work;
    cnt_n = cnt;
    y_n = y;
    err_n = err;
    case (state)
      IDLE: if (start) begin
        work_n = {bcd_in, {BIN_W{1'b0}}};
        cnt_n = 5'(SHIFTS);
        state_n = (CHECK_DIGITS && any_bad_digit(bcd_in)) ? DONE : CONV;
        err_n = CHECK_DIGITS && any_bad_digit(bcd_in);
      end
      CONV: begin
        work_n = {adj, sh[BIN_W-1:0]};
        cnt_n = cnt - 5'd1;
        if (cnt == 5'd1) begin
          y_n = sh[BIN_W-1:0];
          err_n = 1'b0;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed table plus corner sequences for the BCD-to-binary converter
module tb_bcd_to_bin_seq;
  logic clk = 1'b0;
  logic reset, start;
  logic [3:0] ones, tens, hundreds, thousands;
  logic [15:0] y;
  logic busy, done, err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bcd_to_bin_seq #(.BIN_W(16), .CHECK_DIGITS(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .y(y), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] th, hu, te, on;
    logic [15:0] ey;
    logic ee;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm, output int t);
    logic got;
    got = 1'b0;
    t = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; t = cyc; end
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run(input logic [3:0] th, hu, te, on, input logic [15:0] ey, input logic ee, input string nm);
    int n, b;
    logic got;
    thousands = th; hundreds = hu; tens = te; ones = on;
    start = 1'b1;
    n = 0; b = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) b++;
      if (done) begin got = 1'b1; n = k; end
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, " latency"}, 32'(n), ee ? 32'd0 : 32'd16);
      chk({nm, " y"}, 32'(y), 32'(ey));
      chk({nm, " err"}, 32'(err), 32'(ee));
      chk({nm, " busy_cycles"}, 32'(b), ee ? 32'd1 : 32'd17);
    end
    @(negedge clk);
    chk({nm, " done_after"}, 32'(done), 32'd0);
    chk({nm, " busy_after"}, 32'(busy), 32'd0);
    chk({nm, " y_hold"}, 32'(y), 32'(ey));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, dn, v;
    tbl[0] = '{4'd0, 4'd0, 4'd2, 4'd0, 16'h0014, 1'b0};
    tbl[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 16'h270F, 1'b0};
    tbl[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0};
    tbl[3] = '{4'd1, 4'd2, 4'd3, 4'd4, 16'h04D2, 1'b0};
    tbl[4] = '{4'd1, 4'd2, 4'hA, 4'd4, 16'h04D2, 1'b1};
    tbl[5] = '{4'd9, 4'd0, 4'd0, 4'd0, 16'd9000, 1'b0};
    tbl[6] = '{4'hF, 4'd0, 4'd0, 4'd0, 16'd9000, 1'b1};
    tbl[7] = '{4'd0, 4'd0, 4'd0, 4'd9, 16'd9, 1'b0};
    tbl[8] = '{4'd0, 4'd0, 4'd4, 4'd2, 16'd42, 1'b0};
    tbl[9] = '{4'd5, 4'd6, 4'd7, 4'd8, 16'h162E, 1'b0};
    start = 1'b0; ones = '0; tens = '0; hundreds = '0; thousands = '0;
    reset = 1'b1;
    #2;
    chk("reset y", 32'(y), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      run(tbl[i].th, tbl[i].hu, tbl[i].te, tbl[i].on, tbl[i].ey, tbl[i].ee, $sformatf("vec%0d", i));

    thousands = 4'd0; hundreds = 4'd0; tens = 4'd4; ones = 4'd2;
    start = 1'b1;
    wait_done("hold1", t1);
    chk("hold1 y", 32'(y), 32'd42);
    repeat (5) @(negedge clk);
    chk("hold busy", 32'(busy), 32'd1);
    thousands = 4'd9; hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
    wait_done("hold2", t2);
    chk("hold period", 32'(t2 - t1), 32'd18);
    chk("hold2 y", 32'(y), 32'd42);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold idle", 32'(busy), 32'd0);

    thousands = 4'd5; hundreds = 4'd6; tens = 4'd7; ones = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort y", 32'(y), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    dn = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort no_activity", 32'(dn), 32'd0);
    run(4'd5, 4'd6, 4'd7, 4'd8, 16'h162E, 1'b0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      v = $urandom_range(0, 9999);
      run(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), 16'(v), 1'b0, $sformatf("rand%0d_%0d", i, v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
